// File: rtl/midi_stream_decoder.sv
// MIDI byte-stream decoder: running status, channel filter, real-time/SysEx tolerance, CC window.
// Define MIDI_PITCH_BEND_EN to add the pitch_bend_ready / pitch_bend outputs.
module midi_stream_decoder #(
  parameter logic [15:0] CHANNEL_MASK = 16'hFFFF,
  parameter logic [6:0]  CC_BASE      = 7'd20,
  parameter int          NUM_PARAMS   = 9,
  parameter int          IDX_W        = $clog2(NUM_PARAMS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ready,
  input  logic [7:0]       midi_byte,
  output logic             note_event_ready,
  output logic             note_on,
  output logic [6:0]       note,
  output logic [6:0]       velocity,
  output logic [3:0]       channel,
  output logic             param_change_ready,
  output logic [IDX_W-1:0] param_idx,
  output logic [6:0]       param_value,
  output logic             error
`ifdef MIDI_PITCH_BEND_EN
  ,
  output logic             pitch_bend_ready,
  output logic [13:0]      pitch_bend
`endif
);

  typedef enum logic [1:0] {IDLE, DATA1, DATA2, SYSEX} state_t;

  localparam logic [7:0] CC_END = 8'(int'(CC_BASE) + NUM_PARAMS);

  state_t     state, state_nxt;
  logic [7:0] rs_q, rs_nxt;
  logic       rs_vld_q, rs_vld_nxt;
  logic [6:0] d1_q, d1_nxt;
  logic       note_ev_nxt, param_ev_nxt, err_nxt;
  logic       is_status, is_rt, is_chan, one_byte, chan_ok, cc_hit, vel_nz;
  logic [6:0] cc_off;
`ifdef MIDI_PITCH_BEND_EN
  logic       pb_ev_nxt;
`endif

  assign is_status = midi_byte[7];
  assign is_rt     = (midi_byte[7:3] == 5'b11111);
  assign is_chan   = is_status && (midi_byte[7:4] != 4'hF);
  assign one_byte  = (rs_q[6:4] == 3'd4) || (rs_q[6:4] == 3'd5);
  assign chan_ok   = CHANNEL_MASK[rs_q[3:0]];
  assign cc_off    = d1_q - CC_BASE;
  assign cc_hit    = (d1_q >= CC_BASE) && ({1'b0, d1_q} < CC_END);
  assign vel_nz    = (midi_byte[6:0] != 7'd0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    rs_nxt       = rs_q;
    rs_vld_nxt   = rs_vld_q;
    d1_nxt       = d1_q;
    note_ev_nxt  = 1'b0;
    param_ev_nxt = 1'b0;
    err_nxt      = 1'b0;
`ifdef MIDI_PITCH_BEND_EN
    pb_ev_nxt    = 1'b0;
`endif
    // Real-time bytes are invisible: no branch touches anything for them.
    if (ready && !is_rt) begin
      if (is_chan) begin
        err_nxt    = (state == DATA1) || (state == DATA2);
        rs_nxt     = midi_byte;
        rs_vld_nxt = 1'b1;
        state_nxt  = DATA1;
      end else if (is_status) begin
        rs_vld_nxt = 1'b0;
        state_nxt  = (midi_byte == 8'hF0) ? SYSEX : IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (rs_vld_q) begin
              d1_nxt    = midi_byte[6:0];
              state_nxt = one_byte ? IDLE : DATA2;
            end else begin
              err_nxt = 1'b1;
            end
          end
          DATA1: begin
            d1_nxt    = midi_byte[6:0];
            state_nxt = one_byte ? IDLE : DATA2;
          end
          DATA2: begin
            state_nxt = IDLE;
            if (chan_ok) begin
              case (rs_q[7:4])
                4'h8, 4'h9: note_ev_nxt  = 1'b1;
                4'hB:       param_ev_nxt = cc_hit;
`ifdef MIDI_PITCH_BEND_EN
                4'hE:       pb_ev_nxt    = 1'b1;
`endif
                default: ;
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rs_q               <= 8'd0;
      rs_vld_q           <= 1'b0;
      d1_q               <= 7'd0;
      note_event_ready   <= 1'b0;
      note_on            <= 1'b0;
      note               <= 7'd0;
      velocity           <= 7'd0;
      channel            <= 4'd0;
      param_change_ready <= 1'b0;
      param_idx          <= '0;
      param_value        <= 7'd0;
      error              <= 1'b0;
    end else begin
      rs_q               <= rs_nxt;
      rs_vld_q           <= rs_vld_nxt;
      d1_q               <= d1_nxt;
      note_event_ready   <= note_ev_nxt;
      param_change_ready <= param_ev_nxt;
      error              <= err_nxt;
      // Note off (0x8n) and note on with zero velocity both report velocity 0.
      if (note_ev_nxt) begin
        note_on  <= rs_q[4] && vel_nz;
        note     <= d1_q;
        velocity <= (rs_q[4] && vel_nz) ? midi_byte[6:0] : 7'd0;
        channel  <= rs_q[3:0];
      end
      if (param_ev_nxt) begin
        param_idx   <= cc_off[IDX_W-1:0];
        param_value <= midi_byte[6:0];
        channel     <= rs_q[3:0];
      end
    end
  end

`ifdef MIDI_PITCH_BEND_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pitch_bend_ready <= 1'b0;
      pitch_bend       <= 14'h2000;
    end else begin
      pitch_bend_ready <= pb_ev_nxt;
      if (pb_ev_nxt) pitch_bend <= {midi_byte[6:0], d1_q};
    end
  end
`endif

endmodule

// File: doc/midi_stream_decoder.md
Name: midi_stream_decoder

Overview:
Parametrised MIDI byte-stream decoder, successor to the single-channel decoder. Sits between the MIDI UART receiver and the note/parameter consumers (voice allocator, parameter updater). Adds running status, channel filtering, system real-time/SysEx tolerance and a configurable CC-to-parameter window. Emits one-cycle note and parameter events.

Parameters:
CHANNEL_MASK, 16'hFFFF, bit n set = accept messages on MIDI channel n (0-15).
CC_BASE, 7'd20, first controller number mapped to parameter index 0.
NUM_PARAMS, 9, controllers CC_BASE .. CC_BASE+NUM_PARAMS-1 map to indices 0..NUM_PARAMS-1; CC_BASE+NUM_PARAMS <= 128.
IDX_W, $clog2(NUM_PARAMS), width of param_idx (derived; not overridden).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high
ready  input  1  midi_byte valid this cycle (one-cycle strobe per received byte)
midi_byte  input  8  received MIDI byte
note_event_ready  output  1  one-cycle pulse: note event valid
note_on  output  1  1 = note on, 0 = note off
note  output  7  note number
velocity  output  7  velocity (0 for any note off)
channel  output  4  channel of last note/param event
param_change_ready  output  1  one-cycle pulse: parameter event valid
param_idx  output  IDX_W  parameter index
param_value  output  7  controller value
error  output  1  one-cycle pulse on protocol error

Behaviour:
- Single clock clk; reset synchronous, active-high.
- Reset: all outputs 0, state IDLE, running status invalid.
- Bytes are consumed only on cycles with ready=1; ready=0 cycles change nothing.
- Status classes: 0x80 note off, 0x90 note on, 0xB0 control change (2 data bytes each); 0xA0, 0xE0 consumed, discarded (2 bytes); 0xC0, 0xD0 consumed, discarded (1 byte).
- Real-time bytes 0xF8-0xFF: ignored completely; state, data bytes and running status untouched (may appear mid-message).
- 0xF0 -> SYSEX; all data bytes discarded until any status byte; 0xF7 returns to IDLE; running status cleared on entry to SYSEX and on 0xF1-0xF7.
- States: IDLE, DATA1, DATA2, SYSEX.
  IDLE: channel status -> latch running status, DATA1. Data byte with valid running status -> treat as data1 (running status). Data byte without running status -> error pulse, stay IDLE.
  DATA1: data byte -> latch d1; two-byte class -> DATA2; one-byte class -> IDLE.
  DATA2: data byte -> latch d2, decode, IDLE.
  Any channel status byte in DATA1/DATA2 -> error pulse, abandon partial message, process new status same cycle.
- Decode (completed message, channel bit set in CHANNEL_MASK):
  0x9n, d2!=0 -> note_on=1, velocity=d2. 0x9n, d2=0 -> note_on=0, velocity=0. 0x8n -> note_on=0, velocity=0 regardless of d2.
  0xBn, CC_BASE <= d1 < CC_BASE+NUM_PARAMS -> param_idx=d1-CC_BASE, param_value=d2; other controllers silently dropped.
- Masked-channel messages fully consumed, no event, no error.
- Latency: event pulse and data outputs registered, valid cycle after the edge accepting the final data byte. Data outputs hold until the next event of the same kind.
- note_event_ready and param_change_ready never coincide (one message per final byte).
- Reset mid-message: partial message and running status discarded.

Optional Feature:
MIDI_PITCH_BEND_EN: defined -> adds outputs pitch_bend_ready (1, pulse) and pitch_bend (14, {d2,d1}, reset 14'h2000); 0xEn on accepted channel produces pulse with same latency. Undefined -> ports absent, 0xEn consumed and discarded.

Test Plan:
- 0x90,0x45,0x67 -> one pulse note_event_ready, note_on=1, note=69, velocity=103, channel=0; then 0x05,0x7F (running status) -> second pulse note=5, velocity=127.
- 0x90,0x45,0x00 then 0x80,0x05,0x40 -> two note-off pulses, note_on=0, velocity=0, notes 69 then 5.
- CC_BASE=20, NUM_PARAMS=9: 0xB0,0x15,0x65 -> param_change_ready, param_idx=1, param_value=101; 0xB0,0x40,0x10 -> no pulse.
- 0x80,0x05 then 0x90 -> error pulse at 0x90; following 0x45,0x67 -> note on 69/103. Data byte 0x10 right after reset -> error pulse, no event.
- 0x90,0xF8,0x45,0xFE,0x67 -> note on 69/103 exactly as without real-time bytes; 0xF0,0x7D,0x01,0xF7,0x45 -> error pulse at 0x45, no event.
- CHANNEL_MASK=16'h0001: 0x93,0x45,0x67 -> no pulse, no error; next 0x90,0x45,0x67 -> pulse, channel=0; ready held 0 between bytes for 3 cycles -> same result.
